// File: rtl/fsm_mon_pkg.sv
// Shared types, out-decode constants and the legal transition graph for fsm_state_monitor.
package fsm_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OUT_IDLE   = 3'b000;
    localparam logic [2:0] OUT_RUN    = 3'b001;
    localparam logic [2:0] OUT_HOLD   = 3'b010;
    localparam logic [2:0] OUT_DONE   = 3'b100;
    localparam logic [2:0] OUT_LOCKED = 3'b111;

    // Self-loops are always legal; everything else follows the work cycle graph.
    function automatic logic legal_trans(input state_t from, input state_t to);
        logic ok;
        ok = 1'b0;
        if (from == to) begin
            ok = 1'b1;
        end else begin
            case (from)
                IDLE:    ok = (to == RUN);
                RUN:     ok = (to == HOLD) || (to == DONE);
                HOLD:    ok = (to == RUN)  || (to == DONE);
                DONE:    ok = (to == IDLE);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [2:0] decode_out(input state_t s);
        logic [2:0] d;
        case (s)
            IDLE:    d = OUT_IDLE;
            RUN:     d = OUT_RUN;
            HOLD:    d = OUT_HOLD;
            DONE:    d = OUT_DONE;
            default: d = OUT_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fsm_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module fsm_mon_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fsm_state_monitor.sv
// Tracks a requested 2-bit state against the legal graph, flags/counts violations.
// Optional lock-on-first-violation behaviour is enabled by defining FSM_MON_LOCK_EN.
module fsm_state_monitor
    import fsm_mon_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         state_in,
    input  logic               state_valid,
    output logic [2:0]         out,
    output logic [1:0]         cur_state,
    output logic               illegal_trans,
    output logic               err_sticky,
    output logic [ERR_W-1:0]   err_count,
    output logic [DWELL_W-1:0] dwell,
    output logic               locked
);

    // Handshake: state_valid has no ready; every cycle it is high the request is consumed.
    state_t cur_q;
    state_t req;
    logic   lock_q;
    logic   sample;
    logic   is_legal;
    logic   accept;
    logic   reject;

    assign req      = state_t'(state_in);
    assign sample   = state_valid && !lock_q;
    assign is_legal = legal_trans(cur_q, req);
    assign accept   = sample && is_legal && (req != cur_q);
    assign reject   = sample && !is_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q         <= IDLE;
            out           <= OUT_IDLE;
            illegal_trans <= 1'b0;
            err_sticky    <= 1'b0;
`ifdef FSM_MON_LOCK_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            illegal_trans <= reject;
            if (reject) begin
                err_sticky <= 1'b1;
            end
            if (accept) begin
                cur_q <= req;
                out   <= decode_out(req);
            end
`ifdef FSM_MON_LOCK_EN
            // First rejection freezes the tracked state and forces the safe code.
            if (reject) begin
                lock_q <= 1'b1;
                out    <= OUT_LOCKED;
            end
`endif
        end
    end

`ifndef FSM_MON_LOCK_EN
    assign lock_q = 1'b0;
`endif

    assign cur_state = cur_q;
    assign locked    = lock_q;

    fsm_mon_sat_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .clr   (accept),
        .count (dwell)
    );

    fsm_mon_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (reject),
        .clr   (1'b0),
        .count (err_count)
    );

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Randomized and directed bench for fsm_state_monitor against a behavioural model.
// Define FSM_MON_LOCK_EN for both bench and RTL to exercise the lock build.
module tb_fsm_state_monitor;

    localparam int DWELL_W = 8;
    localparam int ERR_W   = 8;
    localparam int DMAX    = (1 << DWELL_W) - 1;
    localparam int EMAX    = (1 << ERR_W) - 1;
`ifdef FSM_MON_LOCK_EN
    localparam bit LOCK_MODE = 1'b1;
`else
    localparam bit LOCK_MODE = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [1:0]         state_in;
    logic               state_valid;
    logic [2:0]         out;
    logic [1:0]         cur_state;
    logic               illegal_trans;
    logic               err_sticky;
    logic [ERR_W-1:0]   err_count;
    logic [DWELL_W-1:0] dwell;
    logic               locked;

    fsm_state_monitor #(.DWELL_W(DWELL_W), .ERR_W(ERR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_in      (state_in),
        .state_valid   (state_valid),
        .out           (out),
        .cur_state     (cur_state),
        .illegal_trans (illegal_trans),
        .err_sticky    (err_sticky),
        .err_count     (err_count),
        .dwell         (dwell),
        .locked        (locked)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int legal_from[6] = '{0, 1, 1, 2, 2, 3};
    int legal_to[6]   = '{1, 2, 3, 1, 3, 0};

    int m_state, m_err, m_dwell;
    bit m_sticky, m_pulse, m_locked;

    function automatic bit model_legal(input int from, input int to);
        if (from == to) return 1'b1;
        for (int i = 0; i < 6; i++)
            if (legal_from[i] == from && legal_to[i] == to) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_out();
        if (m_locked) return 7;
        if (m_state == 0) return 0;
        return 1 << (m_state - 1);
    endfunction

    task automatic model_reset();
        m_state = 0; m_err = 0; m_dwell = 0;
        m_sticky = 0; m_pulse = 0; m_locked = 0;
    endtask

    task automatic model_step(input bit v, input int code);
        m_pulse = 0;
        if (v && !m_locked && model_legal(m_state, code) && code != m_state) begin
            m_state = code;
            m_dwell = 0;
        end else begin
            m_dwell = (m_dwell < DMAX) ? m_dwell + 1 : DMAX;
            if (v && !m_locked && !model_legal(m_state, code)) begin
                m_pulse  = 1;
                m_sticky = 1;
                m_err    = (m_err < EMAX) ? m_err + 1 : EMAX;
                if (LOCK_MODE) m_locked = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cur_state"},     cur_state,     m_state);
        check({tag, ".out"},           out,           model_out());
        check({tag, ".illegal_trans"}, illegal_trans, m_pulse);
        check({tag, ".err_sticky"},    err_sticky,    m_sticky);
        check({tag, ".err_count"},     err_count,     m_err);
        check({tag, ".dwell"},         dwell,         m_dwell);
        check({tag, ".locked"},        locked,        m_locked);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; drives, waits one edge, then checks.
    task automatic cycle(input bit v, input int code, input string tag);
        state_valid = v;
        state_in    = code[1:0];
        @(posedge clk);
        model_step(v, code);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst_n       = 1'b1;
        state_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int seq_codes[5] = '{1, 2, 1, 3, 0};
    int seq_outs[5]  = '{1, 2, 1, 4, 0};

    initial begin
        rst_n       = 1'b0;
        state_valid = 1'b0;
        state_in    = 2'd0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Legal work cycle, one request per cycle.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, seq_codes[i], "seq");
            check("seq.out_const", out, seq_outs[i]);
        end
        check("seq.err_count_zero", err_count, 0);

        // IDLE -> DONE is rejected, then IDLE -> RUN.
        cycle(1'b1, 3, "idle_to_done");
        check("idle_to_done.pulse", illegal_trans, 1);
        check("idle_to_done.cnt", err_count, 1);
        cycle(1'b1, 1, "then_run");
        check("then_run.pulse_gone", illegal_trans, 0);
`ifndef FSM_MON_LOCK_EN
        check("then_run.out", out, 3'b001);
`endif

        // Dwell saturation with no valid requests, then a legal change.
        async_reset("rst_before_dwell");
        for (int i = 0; i < 300; i++) cycle(1'b0, $urandom_range(0, 3), "idle_dwell");
        check("dwell.sat", dwell, DMAX);
        cycle(1'b1, 1, "dwell_change");
        check("dwell.cleared", dwell, 0);

`ifndef FSM_MON_LOCK_EN
        // 260 back-to-back rejections: RUN -> IDLE every cycle.
        for (int i = 0; i < 260; i++) begin
            cycle(1'b1, 0, "err_burst");
            check("err_burst.pulse", illegal_trans, 1);
        end
        check("err_burst.sat", err_count, EMAX);
`else
        async_reset("rst_before_lock");
        cycle(1'b1, 1, "lock_run");
        cycle(1'b1, 0, "lock_trip");
        check("lock.locked", locked, 1);
        check("lock.out", out, 3'b111);
        cycle(1'b1, 2, "lock_ignored");
        check("lock.no_pulse", illegal_trans, 0);
        check("lock.count_held", err_count, 1);
        async_reset("lock_release");
        check("lock.out_after_rst", out, 3'b000);
`endif

        // Reach HOLD with five rejections, then reset asynchronously.
        async_reset("rst_before_hold");
        cycle(1'b1, 1, "to_run");
        cycle(1'b1, 2, "to_hold");
        for (int i = 0; i < 5; i++) cycle(1'b1, 0, "hold_illegal");
        async_reset("rst_in_hold");

        // Randomized back-to-back traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_state_monitor.md
# fsm_state_monitor

Reader-side companion to the user-driven 2-bit state register: samples the requested state code each cycle, checks every change against the legal transition graph, and drives a decoded 3-bit `out`. Illegal requests are rejected: the tracked state holds, the violation is flagged and counted, and the block can optionally lock into a safe state. It sits between the state-request logic and the downstream consumers of `out`.

## Interface
- `DWELL_W`, 8: width of the dwell counter.
- `ERR_W`, 8: width of the illegal-transition counter.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `state_in` input 2: requested state code.
- `state_valid` input 1: `state_in` is sampled only when high.
- `out` output 3: decoded tracked state, registered.
- `cur_state` output 2: tracked (accepted) state.
- `illegal_trans` output 1: one-cycle pulse per rejected request.
- `err_sticky` output 1: set on the first rejection; cleared only by reset.
- `err_count` output ERR_W: count of rejections, saturating.
- `dwell` output DWELL_W: cycles since the last accepted state change, saturating.
- `locked` output 1: lock state active; held at 0 when `FSM_MON_LOCK_EN` is undefined.

## Operation
- Codes: IDLE=0, RUN=1, HOLD=2, DONE=3.
- Legal transitions:
  - IDLE->RUN
  - RUN->HOLD
  - RUN->DONE
  - HOLD->RUN
  - HOLD->DONE
  - DONE->IDLE
  - any self-loop
- Illegal transitions: IDLE->HOLD, IDLE->DONE, RUN->IDLE, HOLD->IDLE, DONE->RUN, DONE->HOLD.
- Cycle with `state_valid`=0: nothing changes except `dwell`.
- Accepted change (legal and different from `cur_state`): `cur_state` takes `state_in`; `dwell` goes to 0.
- Self-loop: legal, not a change; `dwell` keeps counting.
- Illegal request:
  - `cur_state` holds.
  - `illegal_trans` pulses high for 1 cycle.
  - `err_count` increments, saturating at 2^ERR_W-1.
  - `err_sticky` sets.
- `out` decode of `cur_state`: IDLE 3'b000, RUN 3'b001, HOLD 3'b010, DONE 3'b100. Value 3'b111 appears only while `locked`.
- `dwell` increments every cycle except on an accepted change; it saturates at 2^DWELL_W-1.
- Reset values: `cur_state`=IDLE, `out`=3'b000, `illegal_trans`=0, `err_sticky`=0, `err_count`=0, `dwell`=0, `locked`=0.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous).

## Timing
- All outputs are registered.
- A request sampled at edge N appears on `cur_state`, `out` and `illegal_trans` after edge N, i.e. 1-cycle latency.
- Back-to-back requests are accepted every cycle. Each request is checked against the `cur_state` updated by the previous one, never against the previous `state_in`.
- Consecutive illegal requests give `illegal_trans` high on consecutive cycles, with one count per cycle.
- An illegal request arriving when `err_count` is already saturated still pulses `illegal_trans`; the count stays at its maximum.

## Configuration
- `FSM_MON_LOCK_EN` defined:
  - The first illegal request sets `locked` on the same edge that pulses `illegal_trans`.
  - While `locked`: `out`=3'b111, `cur_state` is frozen, all further `state_in` is ignored (no pulses, no counting), and `dwell` keeps counting.
  - Only `rst_n` clears `locked`.
- `FSM_MON_LOCK_EN` undefined:
  - No lock logic is present; `locked` is tied to 0.
  - Monitoring continues indefinitely after any violation.

## Structure
- Shared package `fsm_mon_pkg` holds:
  - the state enum typedef (IDLE/RUN/HOLD/DONE, 2 bits);
  - the four `out` decode constants and the locked-value constant 3'b111;
  - a pure function `legal_trans(from, to)`.
- One sub-module, `fsm_mon_sat_cnt`: a parameterised saturating counter with inc and clr inputs, used for both `dwell` and `err_count`.

## Test plan
- Reset, then sequence IDLE->RUN->HOLD->RUN->DONE->IDLE, one request per cycle: `out` = 001, 010, 001, 100, 000; `illegal_trans` never high; `err_count`=0.
- From IDLE, request DONE: `cur_state` stays 0; `illegal_trans` high 1 cycle; `err_count`=1; `err_sticky`=1. Then request RUN: accepted, `out`=001.
- Hold `state_valid`=0 for 300 cycles with DWELL_W=8: `dwell` saturates at 255. Then make a legal change: `dwell`=0 on the next cycle.
- Without `FSM_MON_LOCK_EN`, 260 consecutive illegal requests with ERR_W=8: `err_count`=255, and `illegal_trans` is high on all 260 cycles.
- With `FSM_MON_LOCK_EN`: RUN, then IDLE (illegal) gives `locked`=1 and `out`=3'b111. A following HOLD request gives no pulse and no count change. Pulsing `rst_n` low mid-cycle restores IDLE, `out`=000, `locked`=0.
- Reset asserted while in HOLD with `err_count`=5: all outputs return to reset values without waiting for a clock edge.
